ripple_adder4_reg: RTL and testbench

//  Registered 4-bit ripple-carry adder: sum/cout of a + b + cin, plus signed overflow.

---
 rtl/ripple_adder4_reg.sv | 122 ++++++++++++
 tb/tb_ripple_adder4_reg.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/ripple_adder4_reg.sv
// ripple_adder4_reg: registered ripple-carry adder with signed overflow.
//
// The adder is a chain of 1-bit full-adder cells. Each bit is built twice:
// once as a behavioural truth-table cell and once as a dataflow XOR/AND-OR
// cell. Both chains are compared on {cout, sum}, and disagreement is flagged.
// The reported result always comes from the behavioural chain.
//
// Parameters:
//   WIDTH     operand/sum width in bits (only 4 is verified)
//   CHECK_EN  1 = build the dataflow shadow chain and drive mismatch;
//             0 = mismatch is tied to 0
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operands valid this cycle
//   a, b       operands, unsigned (two's complement for ovf)
//   cin        carry into bit 0
//   out_valid  result registers hold a captured operation
//   sum        registered (a + b + cin) mod 2^WIDTH
//   cout       registered carry out of the MSB
//   ovf        registered signed overflow (carry into MSB ^ carry out of MSB)
//   mismatch   registered disagreement between the two chains
module ripple_adder4_reg #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned CHECK_EN = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             mismatch
);

  // Behavioural chain: each cell is a truth table on {a_i, b_i, c_i}.
  logic [WIDTH:0]   c_beh;
  logic [WIDTH-1:0] s_beh;

  always_comb begin
    c_beh    = '0;
    s_beh    = '0;
    c_beh[0] = cin;
    for (int i = 0; i < int'(WIDTH); i++) begin
      unique case ({a[i], b[i], c_beh[i]})
        3'b000: begin s_beh[i] = 1'b0; c_beh[i+1] = 1'b0; end
        3'b001: begin s_beh[i] = 1'b1; c_beh[i+1] = 1'b0; end
        3'b010: begin s_beh[i] = 1'b1; c_beh[i+1] = 1'b0; end
        3'b011: begin s_beh[i] = 1'b0; c_beh[i+1] = 1'b1; end
        3'b100: begin s_beh[i] = 1'b1; c_beh[i+1] = 1'b0; end
        3'b101: begin s_beh[i] = 1'b0; c_beh[i+1] = 1'b1; end
        3'b110: begin s_beh[i] = 1'b0; c_beh[i+1] = 1'b1; end
        3'b111: begin s_beh[i] = 1'b1; c_beh[i+1] = 1'b1; end
        default: begin s_beh[i] = 1'b0; c_beh[i+1] = 1'b0; end
      endcase
    end
  end

  // Signed overflow: carry into the MSB differs from carry out of it.
  logic ovf_beh;
  assign ovf_beh = c_beh[WIDTH-1] ^ c_beh[WIDTH];

  // Dataflow shadow chain, compared against the behavioural one.
  logic mismatch_comb;

  if (CHECK_EN != 0) begin : g_check
    logic [WIDTH:0]   c_df;
    logic [WIDTH-1:0] s_df;

    always_comb begin
      c_df    = '0;
      s_df    = '0;
      c_df[0] = cin;
      for (int i = 0; i < int'(WIDTH); i++) begin
        s_df[i]   = a[i] ^ b[i] ^ c_df[i];
        c_df[i+1] = (a[i] & b[i]) | (c_df[i] & (a[i] ^ b[i]));
      end
    end

    assign mismatch_comb = ({c_df[WIDTH], s_df} != {c_beh[WIDTH], s_beh});
  end else begin : g_no_check
    assign mismatch_comb = 1'b0;
  end

  // Result registers. A cycle without in_valid drops out_valid but keeps the
  // last captured result on the data outputs.
  logic             out_valid_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;
  logic             mismatch_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      mismatch_q  <= 1'b0;
    end else begin
      out_valid_q <= in_valid;
      if (in_valid) begin
        sum_q      <= s_beh;
        cout_q     <= c_beh[WIDTH];
        ovf_q      <= ovf_beh;
        mismatch_q <= mismatch_comb;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign mismatch  = mismatch_q;

endmodule

// File: tb/tb_ripple_adder4_reg.sv
// Testbench for ripple_adder4_reg: directed steps with hand-computed results
// and an exhaustive sweep against an independent arithmetic model.
// Observed word layout: {out_valid, cout, ovf, mismatch, sum[3:0]}.
module tb_ripple_adder4_reg;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] a;
  logic [3:0] b;
  logic       cin;
  logic       out_valid;
  logic [3:0] sum;
  logic       cout;
  logic       ovf;
  logic       mismatch;

  int n_cmp = 0;
  int n_err = 0;

  ripple_adder4_reg #(
    .WIDTH    (4),
    .CHECK_EN (1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .mismatch  (mismatch)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] exp);
    logic [7:0] obs;
    obs = {out_valid, cout, ovf, mismatch, sum};
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b required %b", tag, obs, exp);
    end
  endtask

  // Present one operation at the falling edge, check it just after the next rising edge.
  task automatic step(input logic [3:0] ta, input logic [3:0] tb_v, input logic tc,
                      input logic [7:0] exp, input string tag);
    @(negedge clk);
    a        = ta;
    b        = tb_v;
    cin      = tc;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    check(tag, exp);
  endtask

  // Independent model: 5-bit arithmetic sum, signed overflow from operand/result signs.
  function automatic logic [7:0] golden(input logic [3:0] ga, input logic [3:0] gb,
                                        input logic gc);
    logic [4:0] s5;
    logic       o;
    s5 = {1'b0, ga} + {1'b0, gb} + {4'b0, gc};
    o  = (ga[3] == gb[3]) && (s5[3] != ga[3]);
    return {1'b1, s5[4], o, 1'b0, s5[3:0]};
  endfunction

  initial begin
    rst_n    = 1'b1;
    in_valid = 1'b0;
    a        = 4'h0;
    b        = 4'h0;
    cin      = 1'b0;

    // Asynchronous reset with busy operands, before any clock edge.
    #1;
    rst_n    = 1'b0;
    a        = 4'hF;
    b        = 4'hF;
    cin      = 1'b1;
    in_valid = 1'b1;
    #1;
    check("reset_async", 8'b0000_0000);
    @(posedge clk);
    #1;
    check("reset_held_edge", 8'b0000_0000);

    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("release_idle", 8'b0000_0000);

    // 1-bit exhaustive
    for (int i = 0; i < 8; i++) begin
      logic [3:0] ta;
      logic [3:0] tbv;
      logic       tc;
      ta  = {3'b000, i[2]};
      tbv = {3'b000, i[1]};
      tc  = i[0];
      step(ta, tbv, tc, golden(ta, tbv, tc), $sformatf("bit1_%0d", i));
    end

    // Hand vectors: {out_valid, cout, ovf, mismatch, sum}
    step(4'h0, 4'h0, 1'b0, 8'b1000_0000, "v_0p0");
    step(4'h8, 4'h8, 1'b0, 8'b1110_0000, "v_8p8");
    step(4'h0, 4'h1, 1'b0, 8'b1000_0001, "v_0p1");
    step(4'h1, 4'h0, 1'b0, 8'b1000_0001, "v_1p0");
    step(4'h1, 4'h1, 1'b0, 8'b1000_0010, "v_1p1");
    step(4'hF, 4'h2, 1'b0, 8'b1100_0001, "v_Fp2");
    step(4'hF, 4'h0, 1'b1, 8'b1100_0000, "ripple_Fp0c1");
    step(4'h7, 4'h1, 1'b0, 8'b1010_1000, "ripple_7p1");

    // Latency: new operands must not show before the capturing edge.
    @(negedge clk);
    a   = 4'h3;
    b   = 4'h4;
    cin = 1'b0;
    #1;
    check("latency_before_edge", 8'b1010_1000);
    @(posedge clk);
    #1;
    check("latency_after_edge", 8'b1000_0111);

    // Gap: out_valid drops, data holds across two idle cycles.
    @(negedge clk);
    in_valid = 1'b0;
    a        = 4'h5;
    b        = 4'h5;
    @(posedge clk);
    #1;
    check("gap_cycle1", 8'b0000_0111);
    @(posedge clk);
    #1;
    check("gap_cycle2", 8'b0000_0111);
    step(4'h9, 4'h9, 1'b1, 8'b1110_0011, "after_gap");

    // Mid-stream reset clears at once; operands during reset are discarded.
    step(4'h8, 4'h8, 1'b0, 8'b1110_0000, "pre_reset");
    #1;
    rst_n = 1'b0;
    a     = 4'hF;
    b     = 4'hF;
    #1;
    check("reset_midstream", 8'b0000_0000);
    @(posedge clk);
    #1;
    check("reset_mid_edge", 8'b0000_0000);
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("reset_mid_release", 8'b0000_0000);

    // Exhaustive back-to-back sweep of {a, b, cin}.
    for (int i = 0; i < 512; i++) begin
      logic [8:0] v;
      v = i[8:0];
      step(v[8:5], v[4:1], v[0], golden(v[8:5], v[4:1], v[0]), $sformatf("exh_%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
